// File: rtl/sa_pkg.sv
// sa_pkg: shared state type and sizing helpers for the systolic array core.
// Widths derive from N and DW so one package serves every array size.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD,
        DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sa_default_aw(input int n, input int dw);
        return 2 * dw + clog2(n);
    endfunction

    function automatic int sa_beats(input int aw, input int dw);
        return (aw + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/sa_core_if.sv
// sa_core_if: operand stream in, result stream out, job control.
// master drives operands and control; slave is the array core.
interface sa_core_if #(
    parameter int DW = 8
);
    logic          en;
    logic          acc_mode;
    logic [DW-1:0] shift_in;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] shift_out;
    logic          out_valid;
    logic          ack;
    logic          busy;

    modport master (
        output en, acc_mode, shift_in, in_valid, out_ready,
        input  shift_out, out_valid, ack, busy
    );

    modport slave (
        input  en, acc_mode, shift_in, in_valid, out_ready,
        output shift_out, out_valid, ack, busy
    );
endinterface

// File: rtl/sa_pe.sv
// sa_pe: one output-stationary MAC cell with registered a/b forwarding.
// acc_nx_o is the accumulator's next value, equal to the stored one when idle.
module sa_pe #(
    parameter int DW = 8,
    parameter int AW = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] a_o,
    output logic signed [DW-1:0] b_o,
    output logic signed [AW-1:0] acc_nx_o
);
    logic signed [2*DW-1:0] prod;
    logic signed [DW-1:0]   a_q, b_q;
    logic signed [AW-1:0]   acc_q, acc_d;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    // Forwarding regs flush to zero outside COMPUTE so no stale operand leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= en_i ? a_i : '0;
            b_q   <= en_i ? b_i : '0;
            acc_q <= acc_d;
        end
    end

    assign a_o      = a_q;
    assign b_o      = b_q;
    assign acc_nx_o = acc_d;
endmodule

// File: rtl/sa_core.sv
// sa_core: N x N output-stationary signed MAC array with a byte-serial
// load / compute / unload controller and a registered result serialiser.
module sa_core
    import sa_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = sa_default_aw(N, DW)
) (
    input  logic     clk,
    input  logic     rst,
    sa_core_if.slave bus
);
    localparam int NN    = N * N;
    localparam int BEATS = sa_beats(AW, DW);
    localparam int LW    = clog2(2 * NN);
    localparam int TW    = clog2(3 * N);
    localparam int EW    = (NN > 1) ? clog2(NN) : 1;
    localparam int BW    = clog2(BEATS) + 1;

    localparam logic [LW-1:0] LD_LAST = LW'(2 * NN - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(3 * N - 3);
    localparam logic [EW-1:0] E_LAST  = EW'(NN - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BEATS - 1);

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [LW-1:0]        ld_q, ld_d;
    logic [TW-1:0]        t_q, t_d;
    logic [EW-1:0]        el_q, el_d;
    logic [BW-1:0]        bt_q, bt_d;
    logic [DW-1:0]        so_q, so_d;
    logic                 ov_q, ov_d;
    logic                 ack_q, ack_d;
    logic                 ld_we, clr, mac_en;

    logic signed [DW-1:0] buf_q    [2*NN];
    logic signed [DW-1:0] left     [N];
    logic signed [DW-1:0] top      [N];
    logic signed [DW-1:0] a_w      [N][N];
    logic signed [DW-1:0] b_w      [N][N];
    logic signed [DW-1:0] unused_a [N];
    logic signed [DW-1:0] unused_b [N];
    logic signed [AW-1:0] acc_nx   [NN];

    function automatic logic [DW-1:0] beat_of(
        input logic signed [AW-1:0] v,
        input int                   b
    );
        logic signed [BEATS*DW-1:0] w;
        w = (BEATS*DW)'(v);
        return w[b*DW +: DW];
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ld_d    = ld_q;
        t_d     = t_q;
        el_d    = el_q;
        bt_d    = bt_q;
        so_d    = so_q;
        ov_d    = ov_q;
        ack_d   = 1'b0;
        ld_we   = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = LOAD;
                    mode_d  = bus.acc_mode;
                    ld_d    = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    ld_we = 1'b1;
                    ld_d  = ld_q + 1'b1;
                    if (ld_q == LD_LAST) begin
                        state_d = COMPUTE;
                        t_d     = '0;
                        clr     = !mode_q;
                    end
                end
            end
            COMPUTE: begin
                t_d = t_q + 1'b1;
                // acc_nx already holds the final-cycle sum for element 0.
                if (t_q == T_LAST) begin
                    state_d = UNLOAD;
                    el_d    = '0;
                    bt_d    = '0;
                    ov_d    = 1'b1;
                    so_d    = beat_of(acc_nx[0], 0);
                end
            end
            UNLOAD: begin
                if (ov_q && bus.out_ready) begin
                    if (bt_q == B_LAST && el_q == E_LAST) begin
                        state_d = DONE;
                        ov_d    = 1'b0;
                        so_d    = '0;
                        ack_d   = 1'b1;
                    end else begin
                        if (bt_q == B_LAST) begin
                            bt_d = '0;
                            el_d = el_q + 1'b1;
                        end else begin
                            bt_d = bt_q + 1'b1;
                        end
                        so_d = beat_of(acc_nx[el_d], int'(bt_d));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            ld_q    <= '0;
            t_q     <= '0;
            el_q    <= '0;
            bt_q    <= '0;
            so_q    <= '0;
            ov_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ld_q    <= ld_d;
            t_q     <= t_d;
            el_q    <= el_d;
            bt_q    <= bt_d;
            so_q    <= so_d;
            ov_q    <= ov_d;
            ack_q   <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2 * NN; k++) buf_q[k] <= '0;
        end else if (ld_we) begin
            buf_q[ld_q] <= bus.shift_in;
        end
    end

    // Row i and column i share the same skew k = t - i.
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
            left[i] = '0;
            top[i]  = '0;
            if (state_q == COMPUTE) begin
                k = int'(t_q) - i;
                if (k >= 0 && k < N) begin
                    left[i] = buf_q[LW'(i * N + k)];
                    top[i]  = buf_q[LW'(NN + k * N + i)];
                end
            end
        end
    end

    assign mac_en = (state_q == COMPUTE);

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_w[i][0] = left[i];
        assign b_w[0][i] = top[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] a_fw, b_fw;
            sa_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .clr_i    (clr),
                .en_i     (mac_en),
                .a_i      (a_w[i][j]),
                .b_i      (b_w[i][j]),
                .a_o      (a_fw),
                .b_o      (b_fw),
                .acc_nx_o (acc_nx[i*N+j])
            );
            if (j < N - 1) begin : g_ra
                assign a_w[i][j+1] = a_fw;
            end else begin : g_ea
                assign unused_a[i] = a_fw;
            end
            if (i < N - 1) begin : g_rb
                assign b_w[i+1][j] = b_fw;
            end else begin : g_eb
                assign unused_b[j] = b_fw;
            end
        end
    end

    assign bus.shift_out = so_q;
    assign bus.out_valid = ov_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/sa_core.md
# sa_core

Parametrised, pad-less successor to the fixed 8-bit systolic array core. It is an N×N output-stationary signed multiply-accumulate array with a byte-serial load/compute/unload controller. Operands stream in over a DW-bit bus with a valid qualifier, and results stream out with a valid/ready handshake. The block sits directly behind the chip IO pad ring; the top level only adds pads.

## Interface
- N, 4, array dimension; matrices are N×N.
- DW, 8, operand width and IO bus width; operands are signed two's complement.
- AW, 2*DW+clog2(N), accumulator width; must be at least 2*DW.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only in IDLE.
- acc_mode  in  1  captured with en; 1 keeps the previous accumulator contents.
- shift_in  in  DW  operand word.
- in_valid  in  1  shift_in is valid this cycle.
- out_ready  in  1  consumer accepts shift_out this cycle.
- shift_out  out  DW  result beat, registered.
- out_valid  out  1  shift_out holds a valid beat.
- ack  out  1  one-cycle pulse when the job completes.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM: IDLE → LOAD → COMPUTE → UNLOAD → DONE → IDLE.
- IDLE
  - en=1 → LOAD next cycle; acc_mode is latched at the same time.
  - en while not IDLE is ignored.
- LOAD
  - Accepts 2·N² words, one per cycle with in_valid=1; gaps are allowed.
  - Order: A row-major, then B row-major, into internal operand buffers.
  - The last accepted word → COMPUTE.
  - in_valid outside LOAD is ignored.
- COMPUTE, exactly 3N-2 cycles, t = 0..3N-3
  - Left input of row i = A[i][t-i] when 0 ≤ t-i < N, else 0.
  - Top input of column j = B[t-j][j] when 0 ≤ t-j < N, else 0.
  - Each PE(i,j): acc += a·b with full-width sign-extended product; forwards a right and b down through registers.
  - Result: PE(i,j) sees A[i][k] and B[k][j] together at t = k+i+j.
  - On entry, all accumulators clear unless the latched acc_mode=1.
  - Accumulators wrap modulo 2^AW; there is no saturation.
- UNLOAD
  - Emits C row-major.
  - Each element is sent as BEATS = ceil(AW/DW) beats, LSB first, sign-extended to BEATS·DW bits.
  - A beat transfers when out_valid && out_ready.
  - shift_out and out_valid stay stable while out_ready=0.
  - The last transfer → DONE.
- DONE
  - ack=1 for exactly one cycle, then IDLE.
  - Accumulators are retained for the next acc_mode=1 job.
- rst (any state, including mid-job)
  - Next state IDLE; all accumulators and buffers clear.
  - shift_out=0, out_valid=0, ack=0, busy=0.
  - These are also the reset values of every output.

## Timing
- en high on cycle c → busy high on cycle c+1.
- Minimum job length, with in_valid and out_ready held high: 1 + 2N² + (3N-2) + N²·BEATS + 1 cycles.
- First out_valid is the cycle after the final COMPUTE cycle.
- ack is asserted the cycle after the final beat handshake; busy falls together with ack.
- shift_out, out_valid and ack are driven from flops, with no input-to-output combinational paths.

## Structure
- sa_pkg holds:
  - state enum {IDLE, LOAD, COMPUTE, UNLOAD, DONE};
  - clog2 function;
  - BEATS derivation;
  - default AW expression.
- One sub-module, sa_pe: registered a/b forwarding, signed MAC, synchronous clear.
  - It is instantiated N² times via generate.
- Controller, buffers, skew muxing and the output serialiser stay in sa_core.

## Test plan
- N=2, DW=8 (AW=17, BEATS=3): load A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  - Expect beats 19,0,0, 22,0,0, 43,0,0, 50,0,0, then a single ack pulse.
- All operands = -128 at N=2.
  - Each C = 32768; beats 0x00,0x80,0x00 per element.
- Repeat the first job with acc_mode=1.
  - Expect C = [[38,44],[86,100]]; with acc_mode=0, the original result again.
- in_valid toggling 1-0 and out_ready held low for 3 cycles mid-element.
  - Correct C; shift_out is constant during the stall; no beat is lost or duplicated.
- rst asserted after 3 LOAD words, then a fresh full job.
  - Outputs zero and busy=0 the cycle after rst; the fresh job gives the correct C.
- en pulsed during COMPUTE and UNLOAD.
  - Ignored: exactly one ack, and busy never re-enters LOAD early.
